tile_fetch_sequencer: RTL and testbench

//  Per-line draw-side sequencer sitting directly upstream of tile_bram/pixel_quadrupler.
//  On each line_start it walks one display line's worth of 16-bit tile words (4 px each),

---
 rtl/vdp_pkg.sv | 28 ++
 rtl/tile_fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_tile_fetch_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================
// Package : vdp_pkg
// Brief   : Shared types and geometry constants for the VDP draw path
// Rev     : 1.0
// ============================================================
package vdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    localparam int TILE_PX = 8;
    localparam int WORD_PX = 4;
    localparam int QUAD    = 4;
    localparam int MAP_W   = 32;

    typedef struct packed {
        logic [4:0] tile_y;
        logic [4:0] tile_x;
        logic [2:0] tile_row;
        logic       tile_col;
    } tile_addr_t;

endpackage
`default_nettype wire

// File: rtl/tile_fetch_sequencer.sv
`default_nettype none
// ============================================================
// Module  : tile_fetch_sequencer
// Brief   : Walks one display line of scrolled tile words with valid/ready
// Rev     : 1.0
// ============================================================
module tile_fetch_sequencer
    import vdp_pkg::*;
#(
    parameter int CORDW          = 11,
    parameter int WORDS_PER_LINE = 41,
    parameter int LB_STEP        = 16
) (
    input  logic             clk_draw,
    input  logic             rst_draw_n,
    input  logic             line_start,
    input  logic [CORDW-1:0] line_y,
    input  logic [CORDW-1:0] scroll_x,
    input  logic [CORDW-1:0] scroll_y,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [4:0]       tile_y,
    output logic [4:0]       tile_x,
    output logic [2:0]       tile_row,
    output logic             tile_col,
    output logic [CORDW-1:0] lb_x,
    output logic             first_word,
    output logic             bufsel,
    output logic             busy,
    output logic             line_done,
    output logic             overrun
);

    localparam int                c_IDX_W    = $clog2(WORDS_PER_LINE);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS_PER_LINE - 1);

    fetch_state_t       r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [5:0]         r_w;
    logic [CORDW-1:0]   r_lb_x;
    logic [4:0]         r_tile_y;
    logic [2:0]         r_tile_row;
    logic               r_valid;
    logic               r_first;
    logic               r_bufsel;
    logic               r_overrun;

    logic [CORDW-1:0]   w_vy;
    logic [CORDW-1:0]   w_lb_x0;
    tile_addr_t         w_addr;
    logic               w_unused;

    assign w_vy    = line_y + scroll_y;
    assign w_lb_x0 = {CORDW{1'b0}} - {{(CORDW-4){1'b0}}, scroll_x[3:0]};
    // Only the low 6 bits of the word index matter: tile_x wraps on the 32-wide map.
    assign w_unused = &{1'b0, scroll_x[CORDW-1:10], w_vy[CORDW-1:10], w_vy[1:0]};

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_w        <= '0;
            r_lb_x     <= '0;
            r_tile_y   <= '0;
            r_tile_row <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_bufsel   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (line_start) begin
                // DONE may chain straight into a new line; only FETCH is an abort.
                r_overrun  <= (r_state == FETCH);
                r_state    <= FETCH;
                r_idx      <= '0;
                r_w        <= scroll_x[9:4];
                r_lb_x     <= w_lb_x0;
                r_tile_y   <= w_vy[9:5];
                r_tile_row <= w_vy[4:2];
                r_bufsel   <= line_y[0];
                r_first    <= 1'b1;
                r_valid    <= 1'b1;
            end else begin
                case (r_state)
                    FETCH: begin
                        if (out_ready) begin
                            r_first <= 1'b0;
                            if (r_idx == c_LAST_IDX) begin
                                r_state <= DONE;
                                r_valid <= 1'b0;
                            end else begin
                                r_idx  <= r_idx + c_IDX_W'(1);
                                r_w    <= r_w + 6'd1;
                                r_lb_x <= r_lb_x + CORDW'(LB_STEP);
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_addr = '{tile_y: r_tile_y, tile_x: r_w[5:1], tile_row: r_tile_row, tile_col: r_w[0]};

    assign out_valid  = r_valid;
    assign tile_y     = w_addr.tile_y;
    assign tile_x     = w_addr.tile_x;
    assign tile_row   = w_addr.tile_row;
    assign tile_col   = w_addr.tile_col;
    assign lb_x       = r_lb_x;
    assign first_word = r_first;
    assign bufsel     = r_bufsel;
    assign busy       = (r_state != IDLE);
    assign line_done  = (r_state == DONE);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_sequencer.sv
`default_nettype none
// ============================================================
// Module  : tb_tile_fetch_sequencer
// Brief   : Directed self-checking bench for tile_fetch_sequencer
// Rev     : 1.0
// ============================================================
module tb_tile_fetch_sequencer;

    logic        clk_draw = 1'b0;
    logic        rst_draw_n;
    logic        line_start;
    logic [10:0] line_y;
    logic [10:0] scroll_x;
    logic [10:0] scroll_y;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  tile_y;
    logic [4:0]  tile_x;
    logic [2:0]  tile_row;
    logic        tile_col;
    logic [10:0] lb_x;
    logic        first_word;
    logic        bufsel;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    tile_fetch_sequencer dut (
        .clk_draw   (clk_draw),
        .rst_draw_n (rst_draw_n),
        .line_start (line_start),
        .line_y     (line_y),
        .scroll_x   (scroll_x),
        .scroll_y   (scroll_y),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .tile_y     (tile_y),
        .tile_x     (tile_x),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .lb_x       (lb_x),
        .first_word (first_word),
        .bufsel     (bufsel),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    always #5 clk_draw = ~clk_draw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge where word 0 is visible.
    task automatic start_line(input logic [10:0] ly, input logic [10:0] sx, input logic [10:0] sy);
        line_y     = ly;
        scroll_x   = sx;
        scroll_y   = sy;
        line_start = 1'b1;
        @(posedge clk_draw);
        @(negedge clk_draw);
        line_start = 1'b0;
    endtask

    // Checks every visible word and accepts stop_at of them.
    task automatic run_line(input logic [10:0] sx, input logic [4:0] ety, input logic [2:0] etr,
                            input logic eb, input bit toggle, input int stop_at);
        int         acc = 0;
        int         cyc = 0;
        bit         rdy;
        logic [5:0] w;
        logic [10:0] elb;
        while (acc < stop_at && cyc < 200) begin
            w   = sx[9:4] + 6'(acc);
            elb = 11'd0 - {7'd0, sx[3:0]} + 11'(16 * acc);
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("tile_x", {27'd0, tile_x}, {27'd0, w[5:1]});
            chk("tile_col", {31'd0, tile_col}, {31'd0, w[0]});
            chk("lb_x", {21'd0, lb_x}, {21'd0, elb});
            chk("first_word", {31'd0, first_word}, {31'd0, (acc == 0)});
            chk("tile_y", {27'd0, tile_y}, {27'd0, ety});
            chk("tile_row", {29'd0, tile_row}, {29'd0, etr});
            chk("bufsel", {31'd0, bufsel}, {31'd0, eb});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("line_done_mid", {31'd0, line_done}, 32'd0);
            rdy       = toggle ? (cyc[0] == 1'b0) : 1'b1;
            out_ready = rdy;
            @(posedge clk_draw);
            if (rdy) acc++;
            cyc++;
            @(negedge clk_draw);
            out_ready = 1'b1;
        end
        chk("accept_budget", acc, stop_at);
    endtask

    task automatic finish_line();
        chk("line_done", {31'd0, line_done}, 32'd1);
        chk("valid_done", {31'd0, out_valid}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd1);
        @(negedge clk_draw);
        chk("line_done_pulse", {31'd0, line_done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_draw_n = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        scroll_x   = '0;
        scroll_y   = '0;
        out_ready  = 1'b1;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, line_done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_lb_x", {21'd0, lb_x}, 32'd0);
        chk("rst_tile_x", {27'd0, tile_x}, 32'd0);
        chk("rst_first", {31'd0, first_word}, 32'd0);
        @(negedge clk_draw);
        rst_draw_n = 1'b1;
        @(negedge clk_draw);

        // No scroll, full-speed line
        start_line(11'd0, 11'd0, 11'd0);
        run_line(11'd0, 5'd0, 3'd0, 1'b0, 1'b0, 41);
        finish_line();

        // Coarse + fine horizontal scroll
        start_line(11'd0, 11'd37, 11'd0);
        chk("sx37_w0_lb_x", {21'd0, lb_x}, 32'h7FB);
        chk("sx37_w0_tile_x", {27'd0, tile_x}, 32'd1);
        run_line(11'd37, 5'd0, 3'd0, 1'b0, 1'b0, 41);
        finish_line();

        // Vertical scroll: vy = 130
        start_line(11'd100, 11'd0, 11'd30);
        run_line(11'd0, 5'd4, 3'd0, 1'b0, 1'b0, 41);
        finish_line();

        // Backpressure 1010...
        start_line(11'd0, 11'd0, 11'd0);
        run_line(11'd0, 5'd0, 3'd0, 1'b0, 1'b1, 41);
        finish_line();

        // Abort at word 20
        start_line(11'd0, 11'd0, 11'd0);
        run_line(11'd0, 5'd0, 3'd0, 1'b0, 1'b0, 20);
        chk("pre_overrun", {31'd0, overrun}, 32'd0);
        start_line(11'd3, 11'd37, 11'd0);
        chk("overrun_w20", {31'd0, overrun}, 32'd1);
        chk("abort_first", {31'd0, first_word}, 32'd1);
        chk("abort_lb_x", {21'd0, lb_x}, 32'h7FB);
        chk("abort_no_done", {31'd0, line_done}, 32'd0);
        run_line(11'd37, 5'd0, 3'd0, 1'b1, 1'b0, 41);
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);
        finish_line();

        // line_start together with final accept while in FETCH is an overrun
        start_line(11'd5, 11'd0, 11'd0);
        run_line(11'd0, 5'd0, 3'd1, 1'b1, 1'b0, 40);
        start_line(11'd0, 11'd0, 11'd0);
        chk("overrun_last", {31'd0, overrun}, 32'd1);
        chk("last_no_done", {31'd0, line_done}, 32'd0);
        chk("last_first", {31'd0, first_word}, 32'd1);
        run_line(11'd0, 5'd0, 3'd0, 1'b0, 1'b0, 41);
        // line_start while DONE chains with no overrun
        chk("chain_done", {31'd0, line_done}, 32'd1);
        start_line(11'd0, 11'd16, 11'd0);
        chk("chain_no_overrun", {31'd0, overrun}, 32'd0);
        chk("chain_valid", {31'd0, out_valid}, 32'd1);
        run_line(11'd16, 5'd0, 3'd0, 1'b0, 1'b0, 41);
        finish_line();

        // Map wrap then async reset mid-line
        start_line(11'd0, 11'd1000, 11'd0);
        run_line(11'd1000, 5'd0, 3'd0, 1'b0, 1'b0, 40);
        #2 rst_draw_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, line_done}, 32'd0);
        @(negedge clk_draw);
        rst_draw_n = 1'b1;
        @(negedge clk_draw);
        @(negedge clk_draw);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_done", {31'd0, line_done}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
